// File: rtl/ultrasonic_play_detect.sv
// Ultrasonic ranger: periodic trigger, echo-width to cm, far-to-near play_n strobe; echo seen 2 cycles late, no backpressure.
// Optional PLAY_CONFIRM_EN: require two consecutive near readings before play_n fires.
module ultrasonic_play_detect #(
    parameter int CLK_HZ         = 50000000,
    parameter int TRIG_CYCLES    = 500,
    parameter int PERIOD_CYCLES  = 3000000,
    parameter int TIMEOUT_CYCLES = 1500000,
    parameter int CM_CYCLES      = 2900,
    parameter int NEAR_CM        = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       echo_in,
    output logic       trig_out,
    output logic [8:0] dist_cm,
    output logic       dist_valid,
    output logic       play_n
);

    localparam int PER_W  = $clog2(PERIOD_CYCLES + 1);
    localparam int TRIG_W = $clog2(TRIG_CYCLES + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SUB_W  = $clog2(CM_CYCLES + 1);
    localparam int NEAR_CLAMP = (NEAR_CM > 512) ? 512 : ((NEAR_CM < 0) ? 0 : NEAR_CM);
    localparam logic [9:0] NEAR_LIM = 10'(NEAR_CLAMP);
    localparam logic [8:0] DIST_MAX = 9'd511;

    // CLK_HZ only records the clock the cycle-count parameters were derived for.
    if (CLK_HZ > 0) begin : g_clk_hz_documented
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_RISE,
        S_MEASURE,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_sync1;
    logic                r_sync2;
    logic                w_echo;
    logic [PER_W-1:0]    r_period_cnt;
    logic [TRIG_W-1:0]   r_trig_cnt;
    logic [TO_W-1:0]     r_to_cnt;
    logic [SUB_W-1:0]    r_sub_cnt;
    logic [8:0]          r_cm;
    logic [8:0]          r_result;
    logic                r_trig_out;
    logic [8:0]          r_dist_cm;
    logic                r_dist_valid;
    logic                r_play_n;
    logic                r_near;
    logic                w_to_done;
    logic                w_near;
`ifdef PLAY_CONFIRM_EN
    logic                r_confirm;
`endif

    assign w_echo    = r_sync2;
    assign w_to_done = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign w_near    = ({1'b0, r_result} < NEAR_LIM) && (r_result != DIST_MAX);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_period_cnt == '0) begin
                    w_state_nxt = S_TRIG;
                end
            end
            S_TRIG: begin
                if (r_trig_cnt == TRIG_W'(TRIG_CYCLES)) begin
                    w_state_nxt = S_WAIT_RISE;
                end
            end
            S_WAIT_RISE: begin
                if (w_echo) begin
                    w_state_nxt = S_MEASURE;
                end else if (w_to_done) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_MEASURE: begin
                if (!w_echo || w_to_done) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_period_cnt <= '0;
            r_trig_cnt   <= '0;
            r_to_cnt     <= '0;
            r_sub_cnt    <= '0;
            r_cm         <= '0;
            r_result     <= '0;
            r_trig_out   <= 1'b0;
        end else begin
            r_sync1 <= echo_in;
            r_sync2 <= r_sync1;

            if (r_period_cnt == PER_W'(PERIOD_CYCLES - 1)) begin
                r_period_cnt <= '0;
            end else begin
                r_period_cnt <= r_period_cnt + 1'b1;
            end

            // TRIG spends one setup cycle, so trig_out lags the state by one clock
            // and drops on the same edge that enters WAIT_RISE.
            r_trig_out <= (r_state == S_TRIG) && (r_trig_cnt != TRIG_W'(TRIG_CYCLES));
            if (r_state == S_TRIG) begin
                r_trig_cnt <= r_trig_cnt + 1'b1;
            end else begin
                r_trig_cnt <= '0;
            end

            if (w_state_nxt != r_state) begin
                r_to_cnt <= '0;
            end else if (r_state == S_WAIT_RISE || r_state == S_MEASURE) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end else begin
                r_to_cnt <= '0;
            end

            // The rising-edge cycle is itself one echo-high clock and is counted.
            if (r_state == S_WAIT_RISE && w_echo) begin
                r_cm      <= (CM_CYCLES == 1) ? 9'd1 : 9'd0;
                r_sub_cnt <= (CM_CYCLES == 1) ? SUB_W'(0) : SUB_W'(1);
            end else if (r_state == S_MEASURE && w_echo) begin
                if (r_sub_cnt == SUB_W'(CM_CYCLES - 1)) begin
                    r_sub_cnt <= '0;
                    if (r_cm != DIST_MAX) begin
                        r_cm <= r_cm + 9'd1;
                    end
                end else begin
                    r_sub_cnt <= r_sub_cnt + 1'b1;
                end
            end

            if (r_state == S_WAIT_RISE && !w_echo && w_to_done) begin
                r_result <= DIST_MAX;
            end else if (r_state == S_MEASURE) begin
                if (!w_echo) begin
                    r_result <= r_cm;
                end else if (w_to_done) begin
                    r_result <= DIST_MAX;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_dist_cm    <= '0;
            r_dist_valid <= 1'b0;
            r_play_n     <= 1'b1;
            r_near       <= 1'b0;
`ifdef PLAY_CONFIRM_EN
            r_confirm    <= 1'b0;
`endif
        end else begin
            r_dist_valid <= (r_state == S_DONE);
            r_play_n     <= 1'b1;
            if (r_state == S_DONE) begin
                r_dist_cm <= r_result;
`ifdef PLAY_CONFIRM_EN
                if (!w_near) begin
                    r_near    <= 1'b0;
                    r_confirm <= 1'b0;
                end else if (!r_near) begin
                    if (r_confirm) begin
                        r_play_n  <= 1'b0;
                        r_near    <= 1'b1;
                        r_confirm <= 1'b0;
                    end else begin
                        r_confirm <= 1'b1;
                    end
                end
`else
                r_near <= w_near;
                if (w_near && !r_near) begin
                    r_play_n <= 1'b0;
                end
`endif
            end
        end
    end

    assign trig_out   = r_trig_out;
    assign dist_cm    = r_dist_cm;
    assign dist_valid = r_dist_valid;
    assign play_n     = r_play_n;

endmodule

// File: tb/tb_ultrasonic_play_detect.sv
// Bench for ultrasonic_play_detect with short sim parameters; directed table, reset cases, then randomized echoes vs a model.
module tb_ultrasonic_play_detect;

    localparam int TRIG    = 4;
    localparam int PERIOD  = 400;
    localparam int TIMEOUT = 150;
    localparam int CM      = 10;
    localparam int NEAR    = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       echo_in = 1'b0;
    logic       trig_out;
    logic [8:0] dist_cm;
    logic       dist_valid;
    logic       play_n;

    ultrasonic_play_detect #(
        .CLK_HZ(50000000),
        .TRIG_CYCLES(TRIG),
        .PERIOD_CYCLES(PERIOD),
        .TIMEOUT_CYCLES(TIMEOUT),
        .CM_CYCLES(CM),
        .NEAR_CM(NEAR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .echo_in(echo_in),
        .trig_out(trig_out),
        .dist_cm(dist_cm),
        .dist_valid(dist_valid),
        .play_n(play_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        int dly;
        int w;
        int exp_dist;
        int play_single;
        int play_confirm;
    } vec_t;

    vec_t tbl[7];

    int checks = 0;
    int errors = 0;
    int seen_valid = 0;
    int seen_play = 0;
    int last_dist = -1;
    int model_near = 0;
    int model_conf = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (dist_valid === 1'b1) begin
            seen_valid++;
            last_dist = int'(dist_cm);
        end
        if (play_n === 1'b0) begin
            seen_play++;
            check("play_with_valid", int'(dist_valid), 1);
        end
    endtask

    // Echo-high clocks floor-divided into cm; no echo or an echo longer than the timeout reads 511.
    function automatic int model_dist(input int w);
        int d;
        if (w == 0 || w > TIMEOUT) return 511;
        d = w / CM;
        return (d > 511) ? 511 : d;
    endfunction

    function automatic int model_play(input int d);
        int near;
        int fire;
        near = (d < NEAR && d != 511) ? 1 : 0;
        fire = 0;
`ifdef PLAY_CONFIRM_EN
        if (near == 0) begin
            model_near = 0;
            model_conf = 0;
        end else if (model_near == 0) begin
            model_conf++;
            if (model_conf == 2) begin
                fire = 1;
                model_near = 1;
                model_conf = 0;
            end
        end
`else
        fire = (near == 1 && model_near == 0) ? 1 : 0;
        model_near = near;
`endif
        return fire;
    endfunction

    task automatic do_reset();
        echo_in = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_trig", int'(trig_out), 0);
            check("rst_dist", int'(dist_cm), 0);
            check("rst_play_n", int'(play_n), 1);
            check("rst_valid", int'(dist_valid), 0);
        end
        rst = 1'b1;
        tick();
        check("release_edge1_trig", int'(trig_out), 0);
        tick();
        check("release_edge2_trig", int'(trig_out), 1);
        model_near = 0;
        model_conf = 0;
    endtask

    task automatic measure(input int dly, input int w, input int exp_dist, input int exp_play,
                           input bit noise, input string tag);
        int n;
        seen_valid = 0;
        seen_play = 0;
        last_dist = -1;
        n = 0;
        while (trig_out !== 1'b1 && n < 600) begin
            if (noise) echo_in = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        echo_in = 1'b0;
        check({tag, "_trig_seen"}, int'(trig_out === 1'b1), 1);
        n = 0;
        while (trig_out === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        check({tag, "_trig_width"}, n, TRIG);
        repeat (dly) tick();
        if (w > 0) begin
            echo_in = 1'b1;
            repeat (w) tick();
            echo_in = 1'b0;
        end
        n = 0;
        while (seen_valid == 0 && n < 400) begin
            tick();
            n++;
        end
        check({tag, "_valid_count"}, seen_valid, 1);
        check({tag, "_dist"}, last_dist, exp_dist);
        check({tag, "_play_pulses"}, seen_play, exp_play);
    endtask

    initial begin
        int n;
        int w;
        int d;
        int p;
        int seq_w[4];
        int seq_single[4];
        int seq_confirm[4];

        tbl[0] = '{0, 30, 3, 1, 0};
        tbl[1] = '{5, 30, 3, 0, 1};
        tbl[2] = '{0, 120, 12, 0, 0};
        tbl[3] = '{2, 30, 3, 1, 0};
        tbl[4] = '{0, 0, 511, 0, 0};
        tbl[5] = '{0, 300, 511, 0, 0};
        tbl[6] = '{7, 30, 3, 1, 0};

        seq_w       = '{30, 120, 30, 30};
        seq_single  = '{1, 0, 1, 0};
        seq_confirm = '{0, 0, 0, 1};

        do_reset();

        for (int i = 0; i < 7; i++) begin
`ifdef PLAY_CONFIRM_EN
            p = tbl[i].play_confirm;
`else
            p = tbl[i].play_single;
`endif
            void'(model_play(tbl[i].exp_dist));
            measure(tbl[i].dly, tbl[i].w, tbl[i].exp_dist, p, 1'b0, $sformatf("tbl%0d", i));
        end

        // Reset in the middle of an echo: no result, clean restart.
        seen_valid = 0;
        n = 0;
        while (trig_out !== 1'b1 && n < 600) begin tick(); n++; end
        n = 0;
        while (trig_out === 1'b1 && n < 20) begin tick(); n++; end
        echo_in = 1'b1;
        repeat (20) tick();
        do_reset();
        check("midreset_no_valid", seen_valid, 0);

        for (int i = 0; i < 4; i++) begin
`ifdef PLAY_CONFIRM_EN
            p = seq_confirm[i];
`else
            p = seq_single[i];
`endif
            void'(model_play(model_dist(seq_w[i])));
            measure(3, seq_w[i], model_dist(seq_w[i]), p, 1'b0, $sformatf("seq%0d", i));
        end

        for (int i = 0; i < 20; i++) begin
            w = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 140));
            d = int'($urandom_range(0, 60));
            n = model_dist(w);
            p = model_play(n);
            measure(d, w, n, p, 1'b1, $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ultrasonic_play_detect.md
ULTRASONIC_PLAY_DETECT -- requirements
Module: ultrasonic_play_detect

Interface
REQ-001 Parameter CLK_HZ, default 50000000, system clock frequency, documentation only.
REQ-002 Parameter TRIG_CYCLES, default 500, trig_out high time (10 us).
REQ-003 Parameter PERIOD_CYCLES, default 3000000, measurement repetition period (60 ms).
REQ-004 Parameter TIMEOUT_CYCLES, default 1500000, maximum wait for echo rise or fall (30 ms).
REQ-005 Parameter CM_CYCLES, default 2900, echo-high clocks per centimetre (58 us).
REQ-006 Parameter NEAR_CM, default 10, distance below which a reading counts as near.
REQ-007 clk  in  1  system clock; all logic on rising edge.
REQ-008 rst  in  1  reset, synchronous, active-low.
REQ-009 echo_in  in  1  asynchronous echo from the ultrasonic sensor, active-high.
REQ-010 trig_out  out  1  sensor trigger pulse, active-high.
REQ-011 dist_cm  out  9  last measured distance in cm, saturating at 511.
REQ-012 dist_valid  out  1  one-cycle strobe when dist_cm updates.
REQ-013 play_n  out  1  active-low one-cycle play request, feeding the pet-state block's play input.

Function
REQ-014 echo_in shall pass through a 2-flop synchronizer; all decisions use the synchronized value (2-cycle input latency).
REQ-015 A free-running period counter shall count 0..PERIOD_CYCLES-1 and wrap to 0.
REQ-016 FSM states shall be IDLE, TRIG, WAIT_RISE, MEASURE, DONE.
REQ-017 IDLE -> TRIG when period counter is 0; otherwise stay in IDLE.
REQ-018 TRIG: trig_out high for exactly TRIG_CYCLES cycles, then -> WAIT_RISE with trig_out low.
REQ-019 WAIT_RISE: synchronized echo high -> MEASURE with cm count cleared; TIMEOUT_CYCLES elapsed with no rise -> DONE with result 511.
REQ-020 MEASURE: a sub-counter of CM_CYCLES increments the cm count once per CM_CYCLES echo-high cycles; cm count saturates at 511, never wraps.
REQ-021 MEASURE: synchronized echo low -> DONE with the current cm count as result; TIMEOUT_CYCLES elapsed since rise -> DONE with result 511.
REQ-022 DONE (one cycle): load dist_cm with the result, pulse dist_valid high, evaluate the near rule, then -> IDLE.
REQ-023 A reading is near when result < NEAR_CM; result 511 (timeout) is always far.
REQ-024 play_n shall go low for exactly one cycle, the cycle after DONE, on a far-to-near transition only; the near flag re-arms only after a far reading.
REQ-025 Consecutive near readings after a pulse shall not produce further pulses.
REQ-026 Echo activity in IDLE or TRIG shall be ignored.
REQ-027 If the period counter wraps to 0 while a measurement is still in progress, no new TRIG starts until the FSM returns to IDLE and the counter next reaches 0.

Reset
REQ-028 With rst low at a clock edge: FSM IDLE, all counters 0, synchronizer flops 0, trig_out 0, dist_cm 0, dist_valid 0, play_n 1, near flag cleared (far); this applies mid-measurement and aborts it with no dist_valid pulse.
REQ-029 The first TRIG shall start on the second clock edge after rst goes high.

Configuration
REQ-030 Macro PLAY_CONFIRM_EN defined: a near transition requires two consecutive near readings; play_n pulses after the second; one far reading resets the confirm count.
REQ-031 Macro PLAY_CONFIRM_EN undefined: a single near reading after a far reading pulses play_n (REQ-024).

Verification (sim params TRIG_CYCLES=4, PERIOD_CYCLES=400, TIMEOUT_CYCLES=150, CM_CYCLES=10, NEAR_CM=5)
REQ-032 Release reset -> trig_out high 4 cycles starting on the 2nd edge after release; dist_cm=0, play_n=1 throughout reset.
REQ-033 Echo high 30 cycles after trigger -> dist_valid pulse, dist_cm=3, play_n low one cycle (macro off); repeat 30-cycle echo -> no second pulse.
REQ-034 Echo high 120 cycles -> dist_cm=12, no pulse; then 30-cycle echo -> pulse re-armed and fires.
REQ-035 No echo -> dist_cm=511 after 150-cycle timeout, no pulse; echo stuck high -> dist_cm=511 after timeout.
REQ-036 PLAY_CONFIRM_EN defined: near, far, near, near readings -> exactly one play_n pulse, after the 4th reading.
REQ-037 rst low during MEASURE -> no dist_valid, outputs return to reset values, next trigger on the 2nd edge after release.
